process_scheduler: RTL and testbench
====================================

// Module: process_scheduler
// PURPOSE
//  Sequencer directly upstream of the generated per-process instruction blocks.
//  Each step grants every process one clock slot in fixed index order, single threaded, so Java and Verilog traces match.
//  Also: runs initialization steps, counts steps, detects halt or timeout, and strobes the per-step chip trace print.
// PARAMETERS
//  PROCESSES   4    number of processes scheduled, >=1
//  STEP_W      32   signed width of step counter
//  INIT_STEPS  1    unconditional init steps before step 0, >=1
//  MAX_STEPS   100  step count at which run aborts with timeout
//  RC_W        8    per-process return-code width
// PORTS
//  clock         in   1                 sole clock, all state on posedge
//  reset         in   1                 synchronous, active-high
//  start         in   1                 begin run; sampled only in IDLE
//  proc_stop     in   PROCESSES         per-process stop flags
//  proc_rc       in   PROCESSES*RC_W    per-process return codes, process i at [i*RC_W +: RC_W]
//  proc_init     out  1                 high during init steps; processes load reset values
//  proc_grant    out  1                 slot valid; the granted process executes one instruction
//  proc_current  out  $clog2(PROCESSES) index of granted process (width 1 when PROCESSES==1)
//  step          out  STEP_W            signed current step
//  print_strobe  out  1                 1-cycle pulse after each completed step >= 0
//  running       out  1                 high in INIT and RUN states
//  done          out  1                 sticky; run finished because all processes stopped
//  timeout       out  1                 sticky; run finished because step reached MAX_STEPS
//  return_code   out  RC_W              final code; valid while done|timeout
// BEHAVIOUR
//  Reset values:
//   - state=IDLE, step=-INIT_STEPS, proc_current=0.
//   - All other outputs are 0.
//  States:
//   - IDLE -> INIT on start.
//   - INIT -> RUN after INIT_STEPS complete steps.
//   - RUN -> DONE or TIMEOUT at a step boundary.
//   - DONE and TIMEOUT hold until reset.
//  Slots:
//   - In INIT and RUN, proc_grant=1 every cycle.
//   - proc_current counts 0..PROCESSES-1, then wraps to 0. The wrap cycle is the step boundary.
//   - A step therefore lasts PROCESSES cycles.
//  Step boundary:
//   - step increments by 1.
//   - print_strobe asserts in the following cycle, only if the completed step was >= 0.
//  Boundary check (RUN only, after the increment), priority order:
//   - Every proc_stop bit high -> DONE.
//   - Else new step == MAX_STEPS -> TIMEOUT.
//   - Else continue.
//   - proc_stop is sampled only on the boundary cycle. Stops raised mid-step take effect at the next boundary.
//  proc_init:
//   - Equals (state==INIT).
//   - Processes ignore proc_stop while it is high.
//   - Stop is never evaluated during INIT.
//  On entry to DONE:
//   - proc_grant=0, running=0, done=1.
//   - return_code = proc_rc of the lowest-index process with a non-zero code, else 0.
//  On entry to TIMEOUT:
//   - proc_grant=0, running=0, timeout=1, return_code=1.
//  Simultaneous events:
//   - All stopped on the same boundary that reaches MAX_STEPS -> DONE wins.
//   - start while running is ignored.
//  Reset mid-operation: return to IDLE with reset values next cycle. Sticky flags clear.
//  Step counter never wraps: MAX_STEPS < 2**(STEP_W-1) is checked by an elaboration-time assertion.
// CONFIGURATION
//  SCHED_SKIP_STOPPED_EN defined:
//   - RUN slots of processes whose proc_stop is high are skipped: proc_current jumps to the next unstopped index.
//   - A step ends after the last unstopped process.
//   - If all processes are stopped, the boundary is taken immediately.
//  SCHED_SKIP_STOPPED_EN undefined:
//   - Every process is granted every step regardless of stop, giving fixed PROCESSES-cycle steps.
//   - This is the default, required for Java trace lockstep.
//  INIT steps never skip, in either configuration.
// STRUCTURE
//  Package sched_pkg:
//   - sched_state_t enum {IDLE, INIT, RUN, DONE, TIMEOUT}.
//   - RC_TIMEOUT=1 and RC_OK=0 constants.
//  One sub-module, sched_rc_select: combinational lowest-index non-zero priority encoder over proc_rc.
//  Step counter, slot counter and FSM live in the top.
// TESTING
//  Use PROCESSES=4, INIT_STEPS=1, MAX_STEPS=100.
//  1. Reset, then start:
//     - 4 cycles with proc_init=1 and proc_current 0,1,2,3.
//     - Then step=0 and RUN.
//     - First print_strobe after the step-0 boundary, with step=1.
//  2. Raise all proc_stop during step 5:
//     - DONE at the step-5 boundary, step=6.
//     - done=1, running=0, proc_grant=0 next cycle.
//     - return_code=0 when all rc are 0.
//  3. proc_stop never all high:
//     - TIMEOUT when step reaches 100, return_code=1.
//     - Exactly 100 print_strobes and 404 grant cycles from start.
//  4. All stop on the boundary giving step==100, rc=[0,7,3,0]:
//     - done=1, timeout=0, return_code=7.
//  5. Assert reset during RUN at step 42:
//     - IDLE, step=-1 and all outputs 0 next cycle.
//     - A second start repeats scenario 1 exactly.
//  6. SCHED_SKIP_STOPPED_EN with proc_stop=4'b0101 in RUN:
//     - proc_current alternates 1,3.
//     - A step is 2 cycles long.

Source files
------------

// File: rtl/process_scheduler_pkg.sv
// Shared types for the process scheduler: FSM state encoding, return-code constants
// and the width helper for the process index.
package sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    RUN,
    DONE,
    TIMEOUT
  } sched_state_t;

  localparam int RC_OK      = 0;
  localparam int RC_TIMEOUT = 1;

  // Index width, kept at 1 bit when only one process exists.
  function automatic int cur_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/process_scheduler_if.sv
// Bundle between the scheduler (master) and the per-process instruction blocks (slave).
// All slot/step/status outputs come from the master; start, stop flags and return codes come from the slave.
interface process_scheduler_if
  import sched_pkg::*;
#(
  parameter int PROCESSES = 4,
  parameter int STEP_W    = 32,
  parameter int RC_W      = 8
);
  localparam int CUR_W = cur_width(PROCESSES);

  logic                      start;
  logic [PROCESSES-1:0]      proc_stop;
  logic [PROCESSES*RC_W-1:0] proc_rc;
  logic                      proc_init;
  logic                      proc_grant;
  logic [CUR_W-1:0]          proc_current;
  logic signed [STEP_W-1:0]  step;
  logic                      print_strobe;
  logic                      running;
  logic                      done;
  logic                      timeout;
  logic [RC_W-1:0]           return_code;

  modport master (
    input  start, proc_stop, proc_rc,
    output proc_init, proc_grant, proc_current, step, print_strobe,
           running, done, timeout, return_code
  );

  modport slave (
    output start, proc_stop, proc_rc,
    input  proc_init, proc_grant, proc_current, step, print_strobe,
           running, done, timeout, return_code
  );

endinterface

// File: rtl/process_scheduler_rc_select.sv
// Combinational priority pick of the lowest-index non-zero return code (RC_OK when all are zero).
// Zero latency, no handshake.
module sched_rc_select
  import sched_pkg::*;
#(
  parameter int N    = 4,
  parameter int RC_W = 8
) (
  input  logic [N*RC_W-1:0] i_rc,
  output logic [RC_W-1:0]   o_code
);

  always_comb begin
    o_code = RC_W'(RC_OK);
    // Walk downward so the lowest index is the last (winning) assignment.
    for (int i = N - 1; i >= 0; i--) begin
      if (i_rc[i*RC_W +: RC_W] != '0) o_code = i_rc[i*RC_W +: RC_W];
    end
  end

endmodule

// File: rtl/process_scheduler.sv
// Step sequencer: one slot per process per step in index order, init steps, step count, halt/timeout, trace strobe.
// Outputs registered, no backpressure; SCHED_SKIP_STOPPED_EN makes RUN skip slots of stopped processes.
module process_scheduler
  import sched_pkg::*;
#(
  parameter int PROCESSES  = 4,
  parameter int STEP_W     = 32,
  parameter int INIT_STEPS = 1,
  parameter int MAX_STEPS  = 100,
  parameter int RC_W       = 8
) (
  input  logic                clock,
  input  logic                reset,
  process_scheduler_if.master bus
);

  localparam int CUR_W = cur_width(PROCESSES);
  localparam logic signed [STEP_W-1:0] STEP_RST = STEP_W'(-INIT_STEPS);
  localparam logic signed [STEP_W-1:0] STEP_MAX = STEP_W'(MAX_STEPS);

  if (PROCESSES < 1) begin : g_bad_processes
    $error("PROCESSES must be at least 1");
  end
  if (INIT_STEPS < 1) begin : g_bad_init
    $error("INIT_STEPS must be at least 1");
  end
  if (longint'(MAX_STEPS) >= (longint'(1) << (STEP_W - 1))) begin : g_bad_max
    $error("MAX_STEPS does not fit the signed step counter");
  end

  sched_state_t             r_state;
  logic signed [STEP_W-1:0] r_step;
  logic [CUR_W-1:0]         r_cur;
  logic                     r_grant;
  logic                     r_init;
  logic                     r_strobe;
  logic                     r_done;
  logic                     r_timeout;
  logic [RC_W-1:0]          r_rc;

  logic signed [STEP_W-1:0] w_step_inc;
  logic [CUR_W-1:0]         w_inc_cur;
  logic [CUR_W-1:0]         w_first_cur;
  logic [CUR_W-1:0]         w_next_cur;
  logic                     w_last;
  logic                     w_boundary;
  logic [RC_W-1:0]          w_sel_rc;

  sched_rc_select #(.N(PROCESSES), .RC_W(RC_W)) u_rc_select (
    .i_rc  (bus.proc_rc),
    .o_code(w_sel_rc)
  );

  assign w_step_inc = r_step + STEP_W'(1);
  assign w_inc_cur  = CUR_W'(r_cur + 1'b1);

  always_comb begin
    w_last      = (r_cur == CUR_W'(PROCESSES - 1));
    w_first_cur = '0;
    w_next_cur  = w_inc_cur;
    w_boundary  = w_last;
`ifdef SCHED_SKIP_STOPPED_EN
    begin : skip_search
      logic w_found;
      w_found = 1'b0;
      for (int i = PROCESSES - 1; i >= 0; i--) begin
        if (!bus.proc_stop[i]) w_first_cur = CUR_W'(i);
        if (!bus.proc_stop[i] && (i > int'(r_cur))) begin
          w_next_cur = CUR_W'(i);
          w_found    = 1'b1;
        end
      end
      // No unstopped process left after this slot: the step ends here.
      if (r_state == RUN) w_boundary = !w_found;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_step    <= STEP_RST;
      r_cur     <= '0;
      r_grant   <= 1'b0;
      r_init    <= 1'b0;
      r_strobe  <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_rc      <= RC_W'(RC_OK);
    end else begin
      r_strobe <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state <= INIT;
            r_cur   <= '0;
            r_grant <= 1'b1;
            r_init  <= 1'b1;
          end
        end
        INIT: begin
          r_cur <= w_last ? '0 : w_inc_cur;
          if (w_last) begin
            r_step <= w_step_inc;
            if (w_step_inc == '0) begin
              r_state <= RUN;
              r_init  <= 1'b0;
              r_cur   <= w_first_cur;
            end
          end
        end
        RUN: begin
          r_cur <= w_boundary ? w_first_cur : w_next_cur;
          if (w_boundary) begin
            r_step   <= w_step_inc;
            r_strobe <= 1'b1;
            // All-stopped outranks reaching MAX_STEPS on the same boundary.
            if (&bus.proc_stop) begin
              r_state <= DONE;
              r_grant <= 1'b0;
              r_done  <= 1'b1;
              r_rc    <= w_sel_rc;
            end else if (w_step_inc == STEP_MAX) begin
              r_state   <= TIMEOUT;
              r_grant   <= 1'b0;
              r_timeout <= 1'b1;
              r_rc      <= RC_W'(RC_TIMEOUT);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.proc_init    = r_init;
  assign bus.proc_grant   = r_grant;
  assign bus.proc_current = r_cur;
  assign bus.step         = r_step;
  assign bus.print_strobe = r_strobe;
  assign bus.running      = r_grant;
  assign bus.done         = r_done;
  assign bus.timeout      = r_timeout;
  assign bus.return_code  = r_rc;

endmodule

// File: tb/tb_process_scheduler.sv
// Randomized bench for process_scheduler against a slot-counting reference model.
module tb_process_scheduler;

  localparam int P    = 4;
  localparam int RC_W = 8;
  localparam int INIT = 1;
  localparam int MAX  = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  // Model: a run is just a count of granted slots; step and slot index follow by division.
  bit m_active = 1'b0, m_done = 1'b0, m_to = 1'b0, m_strobe = 1'b0;
  int m_slots = 0, m_rc = 0;

  process_scheduler_if #(.PROCESSES(P), .STEP_W(32), .RC_W(RC_W)) sif ();

  process_scheduler #(
    .PROCESSES(P), .STEP_W(32), .INIT_STEPS(INIT), .MAX_STEPS(MAX), .RC_W(RC_W)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (sif.master)
  );

  always #5 clk = ~clk;

  function automatic int m_step();
    return m_slots / P - INIT;
  endfunction

  task automatic model_advance(input logic st, input logic [P-1:0] stp,
                               input logic [P*RC_W-1:0] rc, input logic rs);
    int completed;
    if (rs) begin
      m_active = 0; m_done = 0; m_to = 0; m_strobe = 0; m_slots = 0; m_rc = 0;
      return;
    end
    m_strobe = 0;
    if (m_active) begin
      m_slots++;
      if (m_slots % P == 0) begin
        completed = m_slots / P - INIT - 1;
        if (completed >= 0) begin
          m_strobe = 1;
          if (stp == '1) begin
            m_active = 0; m_done = 1; m_rc = 0;
            for (int i = P - 1; i >= 0; i--)
              if (rc[i*RC_W +: RC_W] != 0) m_rc = int'(rc[i*RC_W +: RC_W]);
          end else if (completed + 1 == MAX) begin
            m_active = 0; m_to = 1; m_rc = 1;
          end
        end
      end
    end else if (!m_done && !m_to && st) begin
      m_active = 1;
    end
  endtask

  function automatic logic [47:0] exp_vec();
    int s;
    s = m_step();
    return {m_active && (s < 0), m_active, 2'(m_slots % P), 32'(s), m_strobe,
            m_active, m_done, m_to, 8'(m_rc)};
  endfunction

  function automatic logic [47:0] dut_vec();
    return {sif.proc_init, sif.proc_grant, sif.proc_current, sif.step, sif.print_strobe,
            sif.running, sif.done, sif.timeout, sif.return_code};
  endfunction

  function automatic logic [3:0] rnd_partial();
    return 4'($urandom_range(0, 14));
  endfunction

  task automatic clk_cycle();
    model_advance(sif.start, sif.proc_stop, sif.proc_rc, rst);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; sif.start = 0; sif.proc_stop = '0; sif.proc_rc = '0;
    clk_cycle();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; sif.start = 0; sif.proc_stop = '0; sif.proc_rc = '0;
    clk_cycle(); clk_cycle();
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL reset_vec: got %h expected %h", dut_vec(), exp_vec());
    end
    checks++;
    if (sif.step !== 32'hFFFF_FFFF || sif.proc_current !== 2'd0) begin
      errors++; $display("FAIL reset_step: got step %0d cur %0d expected -1 and 0", sif.step, sif.proc_current);
    end
    rst = 0;
    clk_cycle(); clk_cycle();
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL idle_hold: got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_start();
    sif.start = 1; clk_cycle(); sif.start = 0;
    for (int i = 0; i < P; i++) begin
      checks++;
      if (sif.proc_init !== 1'b1 || sif.proc_grant !== 1'b1 || sif.proc_current !== 2'(i)) begin
        errors++; $display("FAIL start_init slot %0d: got init %b cur %0d expected init 1 cur %0d",
                           i, sif.proc_init, sif.proc_current, i);
      end
      clk_cycle();
    end
    checks++;
    if (sif.step !== 32'd0 || sif.proc_init !== 1'b0 || sif.running !== 1'b1 || sif.print_strobe !== 1'b0) begin
      errors++; $display("FAIL start_run: got step %0d init %b running %b strobe %b expected 0 0 1 0",
                         sif.step, sif.proc_init, sif.running, sif.print_strobe);
    end
    for (int j = 0; j < P; j++) begin
      clk_cycle();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL start_trace cycle %0d: got %h expected %h", j, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (sif.print_strobe !== 1'b1 || sif.step !== 32'd1) begin
      errors++; $display("FAIL first_strobe: got strobe %b step %0d expected 1 and 1", sif.print_strobe, sif.step);
    end
  endtask

  task automatic test_slots();
    do_reset();
    sif.proc_stop = 4'b0101;
    sif.start = 1; clk_cycle(); sif.start = 0;
    for (int i = 0; i < P; i++) begin
      checks++;
      if (sif.proc_current !== 2'(i) || sif.proc_init !== 1'b1) begin
        errors++; $display("FAIL slots_init %0d: got cur %0d expected %0d", i, sif.proc_current, i);
      end
      clk_cycle();
    end
    for (int j = 0; j < 8; j++) begin
      int ecur, estep;
`ifdef SCHED_SKIP_STOPPED_EN
      ecur = (j % 2 == 0) ? 1 : 3; estep = j / 2;
`else
      ecur = j % P; estep = j / P;
`endif
      checks++;
      if (sif.proc_current !== 2'(ecur) || sif.step !== 32'(estep) || sif.proc_grant !== 1'b1) begin
        errors++; $display("FAIL slots_run %0d: got cur %0d step %0d expected cur %0d step %0d",
                           j, sif.proc_current, sif.step, ecur, estep);
      end
      clk_cycle();
    end
  endtask

  task automatic test_done();
    int stop_at, n;
    stop_at = $urandom_range(0, P - 1);
    do_reset();
    sif.start = 1; clk_cycle(); sif.start = 0;
    n = 0;
    while (!m_done && !m_to && n < 200) begin
      if (m_step() == 5 && (m_slots % P) >= stop_at) begin
        sif.proc_stop = '1; sif.proc_rc = '0;
      end else if (m_step() < 5) begin
        sif.proc_stop = rnd_partial(); sif.proc_rc = $urandom;
      end
      clk_cycle(); n++;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL done_trace cycle %0d: got %h expected %h", n, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (sif.done !== 1'b1 || sif.running !== 1'b0 || sif.proc_grant !== 1'b0 || sif.step !== 32'd6
        || sif.return_code !== 8'd0 || sif.timeout !== 1'b0) begin
      errors++; $display("FAIL done_entry: got done %b run %b grant %b step %0d rc %0d expected 1 0 0 6 0",
                         sif.done, sif.running, sif.proc_grant, sif.step, sif.return_code);
    end
    sif.start = 1; sif.proc_stop = '0; clk_cycle(); clk_cycle(); sif.start = 0;
    checks++;
    if (sif.done !== 1'b1 || sif.proc_grant !== 1'b0 || sif.step !== 32'd6) begin
      errors++; $display("FAIL done_sticky: got done %b grant %b step %0d expected 1 0 6",
                         sif.done, sif.proc_grant, sif.step);
    end
  endtask

  task automatic test_timeout();
    int n, strobes, grants;
    do_reset();
    sif.start = 1; clk_cycle();
    n = 0; strobes = 0; grants = 0;
    if (sif.proc_grant === 1'b1) grants++;
    while (!m_to && !m_done && n < 1000) begin
`ifdef SCHED_SKIP_STOPPED_EN
      sif.proc_stop = '0;
`else
      sif.proc_stop = rnd_partial();
`endif
      sif.start = 1'($urandom_range(0, 1));
      sif.proc_rc = $urandom;
      clk_cycle(); n++;
      if (sif.print_strobe === 1'b1) strobes++;
      if (sif.proc_grant === 1'b1) grants++;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL timeout_trace cycle %0d: got %h expected %h", n, dut_vec(), exp_vec());
      end
    end
    sif.start = 0;
    checks++;
    if (strobes != 100 || grants != 404) begin
      errors++; $display("FAIL timeout_counts: got strobes %0d grants %0d expected 100 and 404", strobes, grants);
    end
    checks++;
    if (sif.timeout !== 1'b1 || sif.done !== 1'b0 || sif.return_code !== 8'd1 || sif.step !== 32'd100
        || sif.running !== 1'b0) begin
      errors++; $display("FAIL timeout_entry: got to %b done %b rc %0d step %0d run %b expected 1 0 1 100 0",
                         sif.timeout, sif.done, sif.return_code, sif.step, sif.running);
    end
  endtask

  task automatic test_simul();
    int k, n;
`ifdef SCHED_SKIP_STOPPED_EN
    k = P - 1;
`else
    k = $urandom_range(0, P - 1);
`endif
    do_reset();
    sif.proc_rc = {8'd0, 8'd3, 8'd7, 8'd0};
    sif.start = 1; clk_cycle(); sif.start = 0;
    n = 0;
    while (!m_done && !m_to && n < 1000) begin
      if (m_step() == 99 && (m_slots % P) >= k) sif.proc_stop = '1;
`ifndef SCHED_SKIP_STOPPED_EN
      else if (m_step() < 99) sif.proc_stop = rnd_partial();
`endif
      clk_cycle(); n++;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL simul_trace cycle %0d: got %h expected %h", n, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (sif.done !== 1'b1 || sif.timeout !== 1'b0 || sif.return_code !== 8'd7 || sif.step !== 32'd100) begin
      errors++; $display("FAIL simul_done_wins: got done %b to %b rc %0d step %0d expected 1 0 7 100",
                         sif.done, sif.timeout, sif.return_code, sif.step);
    end
  endtask

  task automatic test_reset_mid();
    int off, n;
    logic [47:0] rv;
    off = $urandom_range(0, P - 1);
    do_reset();
    sif.start = 1; clk_cycle(); sif.start = 0;
    n = 0;
    while (!(m_step() == 42 && (m_slots % P) == off) && n < 1000) begin
      clk_cycle(); n++;
    end
    checks++;
    if (sif.step !== 32'd42 || sif.running !== 1'b1) begin
      errors++; $display("FAIL mid_reach: got step %0d running %b expected 42 1", sif.step, sif.running);
    end
    rst = 1; clk_cycle();
    rv = '0; rv[43:12] = '1;
    checks++;
    if (dut_vec() !== rv) begin
      errors++; $display("FAIL mid_reset: got %h expected %h", dut_vec(), rv);
    end
    rst = 0;
    test_start();
  endtask

  initial begin
    test_reset();
    test_start();
    test_slots();
`ifndef SCHED_SKIP_STOPPED_EN
    test_done();
`endif
    test_timeout();
    test_simul();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
